// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// uart_tx_scheduler
// Shares one UART TX line between two byte-stream sources, A (CROC softcore)
// and B (STM32 bridge). The line is granted to one source per packet.
// A source header byte goes out first, then the payload bytes follow as
// 8N1 frames. B has strict priority, but A is granted once B has won
// MAX_B_STREAK times in a row while A was waiting. A packet is aborted if
// the granted source leaves the line waiting for its next byte for
// STALL_CYCLES clocks.
//
// Optional build macro: UART_TX_SCHED_PARITY_EN
//   When defined, every frame (header and payload) carries an even-parity bit
//   between data bit 7 and the stop bit, which makes each frame 11 bit times.
//   When undefined, frames are plain 8N1 and no parity logic exists.
module uart_tx_scheduler #(
    parameter int          CLK_FREQ     = 20000000,
    parameter int          BAUD_RATE    = 125000,
    parameter logic [7:0]  HDR_A        = 8'h10,
    parameter logic [7:0]  HDR_B        = 8'h20,
    parameter int          MAX_B_STREAK = 4,
    parameter int          STALL_CYCLES = (CLK_FREQ / BAUD_RATE) * 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    input  logic       a_last,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    input  logic       b_last,
    output logic       b_ready,
    output logic       uart_tx,
    output logic [1:0] grant,
    output logic       busy,
    output logic       abort_pulse
);

    // Clocks per bit must be at least 2 for the baud counter to make sense.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam int BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int STALL_W  = $clog2(STALL_CYCLES + 1);
    localparam int STREAK_W = (MAX_B_STREAK > 0) ? $clog2(MAX_B_STREAK + 1) : 1;

    localparam logic [BAUD_W-1:0]   BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]          BIT_LAST   = 4'(FRAME_BITS - 1);
    localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_B_STREAK);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [FRAME_BITS-1:0]  shift_reg;
    logic [3:0]             bit_cnt;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [STALL_W-1:0]     stall_cnt;
    logic [STREAK_W-1:0]    b_streak;
    logic                   is_header;
    logic                   last_flag;

    logic                   pick_a;
    logic                   pick_b;
    logic                   abort_now;
    logic                   bit_done;
    logic                   frame_done;
    logic                   payload_hs;
    logic [7:0]             pay_data;
    logic                   pay_last;

    // Builds the full on-line bit sequence of one frame, LSB first:
    // start bit, data bits, optional even parity, stop bit.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
`ifdef UART_TX_SCHED_PARITY_EN
        return {1'b1, ^data, data, 1'b0};
`else
        return {1'b1, data, 1'b0};
`endif
    endfunction

    // Handshake, frame timing and payload selection derived from current state.
    always_comb begin
        a_ready    = (state == S_WAIT) && grant[0];
        b_ready    = (state == S_WAIT) && grant[1];
        busy       = (state != S_IDLE);
        bit_done   = (state == S_SHIFT) && (baud_cnt == BAUD_LAST);
        frame_done = bit_done && (bit_cnt == BIT_LAST);
        payload_hs = (a_valid && a_ready) || (b_valid && b_ready);
        pay_data   = grant[1] ? b_data : a_data;
        pay_last   = grant[1] ? b_last : a_last;
    end

    // State register for the packet FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: arbitration in idle, frame completion, payload wait and stall abort.
    always_comb begin
        next_state = state;
        pick_a     = 1'b0;
        pick_b     = 1'b0;
        abort_now  = 1'b0;
        case (state)
            S_IDLE: begin
                if (b_valid && !(a_valid && (b_streak == STREAK_MAX))) begin
                    pick_b     = 1'b1;
                    next_state = S_SHIFT;
                end else if (a_valid) begin
                    pick_a     = 1'b1;
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (frame_done) begin
                    next_state = (is_header || !last_flag) ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                if (payload_hs) begin
                    next_state = S_SHIFT;
                end else if (stall_cnt == STALL_LAST) begin
                    abort_now  = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: grant ownership, starvation streak, shifter, bit/baud/stall counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant       <= 2'b00;
            b_streak    <= '0;
            shift_reg   <= '1;
            bit_cnt     <= '0;
            baud_cnt    <= '0;
            stall_cnt   <= '0;
            is_header   <= 1'b0;
            last_flag   <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= abort_now;
            case (state)
                S_IDLE: begin
                    bit_cnt   <= '0;
                    baud_cnt  <= '0;
                    stall_cnt <= '0;
                    if (pick_b) begin
                        grant     <= 2'b10;
                        shift_reg <= make_frame(HDR_B);
                        is_header <= 1'b1;
                        last_flag <= 1'b0;
                        if (!a_valid) begin
                            b_streak <= '0;
                        end else if (b_streak != STREAK_MAX) begin
                            b_streak <= b_streak + 1'b1;
                        end
                    end else if (pick_a) begin
                        grant     <= 2'b01;
                        shift_reg <= make_frame(HDR_A);
                        is_header <= 1'b1;
                        last_flag <= 1'b0;
                        b_streak  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (bit_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                        if (frame_done) begin
                            bit_cnt   <= '0;
                            stall_cnt <= '0;
                            if (!is_header && last_flag) begin
                                grant <= 2'b00;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (payload_hs) begin
                        shift_reg <= make_frame(pay_data);
                        last_flag <= pay_last;
                        is_header <= 1'b0;
                        bit_cnt   <= '0;
                        baud_cnt  <= '0;
                        stall_cnt <= '0;
                    end else if (abort_now) begin
                        grant     <= 2'b00;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: begin
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Registered line driver: idle high, otherwise the current shifter bit one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= (state == S_SHIFT) ? shift_reg[0] : 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler at 10 clocks per bit. A line decoder
// rebuilds the transmitted bytes, a logger records every grant change, and
// the directed steps compare both against hand-computed expectations.
// Honors UART_TX_SCHED_PARITY_EN the same way as the design.
module tb_uart_tx_scheduler;

    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 100000;
    localparam int CPB       = 10;
    localparam int STALL     = CPB * 24;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_last;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_ready;
    logic       uart_tx;
    logic [1:0] grant;
    logic       busy;
    logic       abort_pulse;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int aHs    = 0;

    logic [7:0] rxQ[$];
    int         rxT[$];
    logic [1:0] gQ[$];
    bit         rxEn   = 1'b0;
    bit         rxMute = 1'b0;
    bit         logEn  = 1'b0;
    logic [1:0] lastGrant = 2'b00;
    logic [7:0] rxByte;
    int         rxStart;

    uart_tx_scheduler #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_RATE   (BAUD_RATE),
        .HDR_A       (8'h10),
        .HDR_B       (8'h20),
        .MAX_B_STREAK(4),
        .STALL_CYCLES(STALL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_last     (a_last),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_last     (b_last),
        .b_ready    (b_ready),
        .uart_tx    (uart_tx),
        .grant      (grant),
        .busy       (busy),
        .abort_pulse(abort_pulse)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Free-running cycle counter and A handshake counter.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (a_valid === 1'b1 && a_ready === 1'b1) aHs <= aHs + 1;
    end

    // Records every change of the grant output.
    always @(negedge clk) begin
        if (logEn && grant !== lastGrant) begin
            gQ.push_back(grant);
            lastGrant = grant;
        end
    end

    // Compares one observed value against its expectation and counts the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Decodes frames from the line, sampling each bit near its middle.
    always begin
        @(negedge clk);
        if (rxEn && uart_tx === 1'b0) begin
            rxStart = cycle;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rxByte[i] = uart_tx;
            end
`ifdef UART_TX_SCHED_PARITY_EN
            repeat (CPB) @(negedge clk);
            if (!rxMute) checkOutput("rx_parity", 32'(uart_tx), 32'(^rxByte));
`endif
            repeat (CPB) @(negedge clk);
            if (!rxMute) checkOutput("rx_stop_bit", 32'(uart_tx), 32'd1);
            rxQ.push_back(rxByte);
            rxT.push_back(rxStart);
        end
    end

    // Presents one byte on a source and returns just after its handshake edge.
    task automatic applyStimulus(input bit toB, input logic [7:0] data, input logic last);
        int n = 0;
        if (toB) begin
            b_valid = 1'b1; b_data = data; b_last = last;
        end else begin
            a_valid = 1'b1; a_data = data; a_last = last;
        end
        @(negedge clk);
        while (((toB ? b_ready : a_ready) !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(toB ? "b_handshake_timeout" : "a_handshake_timeout",
                    32'(toB ? b_ready : a_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Waits for the scheduler to return to idle, bounded.
    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    // Global time limit.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int base;
        int gbase;
        int hsBase;
        int n;
        int cnt;
        int seen;
        logic [7:0] exp4[14];
        logic [1:0] expG4[14];

        rst_n = 1'b0; a_valid = 1'b1; a_data = 8'h41; a_last = 1'b0;
        b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;

        $display("[TB] reset held with a_valid high");
        repeat (5) begin
            @(negedge clk);
            checkOutput("rst_uart_tx", 32'(uart_tx), 32'd1);
            checkOutput("rst_grant", 32'(grant), 32'd0);
            checkOutput("rst_a_ready", 32'(a_ready), 32'd0);
        end
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_abort", 32'(abort_pulse), 32'd0);

        base = rxQ.size(); gbase = gQ.size(); hsBase = aHs;
        rxEn = 1'b1; logEn = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t1_grant_edge", 32'(grant), 32'd1);
        checkOutput("t1_line_idle_on_grant", 32'(uart_tx), 32'd1);
        @(negedge clk);
        checkOutput("t1_start_bit", 32'(uart_tx), 32'd0);

        $display("[TB] single A packet 41 42");
        applyStimulus(1'b0, 8'h41, 1'b0);
        applyStimulus(1'b0, 8'h42, 1'b1);
        a_valid = 1'b0;
        waitIdle();
        checkOutput("t2_handshakes", 32'(aHs - hsBase), 32'd2);
        checkOutput("t2_byte_count", 32'(rxQ.size() - base), 32'd3);
        checkOutput("t2_hdr", 32'(rxQ[base]), 32'h10);
        checkOutput("t2_byte1", 32'(rxQ[base + 1]), 32'h41);
        checkOutput("t2_byte2", 32'(rxQ[base + 2]), 32'h42);
        checkOutput("t2_spacing1", 32'(rxT[base + 1] - rxT[base]), 32'(FRAME + 1));
        checkOutput("t2_spacing2", 32'(rxT[base + 2] - rxT[base + 1]), 32'(FRAME + 1));
        checkOutput("t2_grant_log_len", 32'(gQ.size() - gbase), 32'd2);
        checkOutput("t2_grant_a", 32'(gQ[gbase]), 32'd1);
        checkOutput("t2_grant_off", 32'(gQ[gbase + 1]), 32'd0);

        $display("[TB] simultaneous A and B requests");
        base = rxQ.size(); gbase = gQ.size();
        fork
            begin applyStimulus(1'b0, 8'hA1, 1'b1); a_valid = 1'b0; end
            begin applyStimulus(1'b1, 8'hB1, 1'b1); b_valid = 1'b0; end
        join
        waitIdle();
        checkOutput("t3_byte_count", 32'(rxQ.size() - base), 32'd4);
        checkOutput("t3_hdr_b", 32'(rxQ[base]), 32'h20);
        checkOutput("t3_data_b", 32'(rxQ[base + 1]), 32'hB1);
        checkOutput("t3_hdr_a", 32'(rxQ[base + 2]), 32'h10);
        checkOutput("t3_data_a", 32'(rxQ[base + 3]), 32'hA1);
        checkOutput("t3_grant_log_len", 32'(gQ.size() - gbase), 32'd4);
        checkOutput("t3_grant0", 32'(gQ[gbase]), 32'd2);
        checkOutput("t3_grant1", 32'(gQ[gbase + 1]), 32'd0);
        checkOutput("t3_grant2", 32'(gQ[gbase + 2]), 32'd1);
        checkOutput("t3_grant3", 32'(gQ[gbase + 3]), 32'd0);

        $display("[TB] B streak with A waiting");
        base = rxQ.size(); gbase = gQ.size();
        exp4  = '{8'h20, 8'hC0, 8'h20, 8'hC1, 8'h20, 8'hC2, 8'h20, 8'hC3,
                  8'h10, 8'hA2, 8'h20, 8'hC4, 8'h20, 8'hC5};
        expG4 = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0,
                  2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
        fork
            begin applyStimulus(1'b0, 8'hA2, 1'b1); a_valid = 1'b0; end
            begin
                for (int k = 0; k < 6; k++) applyStimulus(1'b1, 8'(8'hC0 + k), 1'b1);
                b_valid = 1'b0;
            end
        join
        waitIdle();
        checkOutput("t4_byte_count", 32'(rxQ.size() - base), 32'd14);
        checkOutput("t4_grant_log_len", 32'(gQ.size() - gbase), 32'd14);
        for (int i = 0; i < 14; i++) begin
            checkOutput($sformatf("t4_byte%0d", i), 32'(rxQ[base + i]), 32'(exp4[i]));
            checkOutput($sformatf("t4_grant%0d", i), 32'(gQ[gbase + i]), 32'(expG4[i]));
        end

        $display("[TB] stall abort on A with B pending");
        base = rxQ.size();
        applyStimulus(1'b0, 8'h55, 1'b0);
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 8'h66; b_last = 1'b1;
        n = 0;
        @(negedge clk);
        while (a_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_wait_entry", 32'(a_ready), 32'd1);
        cnt = 0; seen = 0;
        while (a_ready === 1'b1 && cnt < 1000) begin
            cnt++;
            if (b_ready !== 1'b0 || abort_pulse !== 1'b0 || uart_tx !== 1'b1) seen++;
            @(negedge clk);
        end
        checkOutput("t5_stall_cycles", 32'(cnt), 32'(STALL));
        checkOutput("t5_quiet_while_waiting", 32'(seen), 32'd0);
        checkOutput("t5_abort_pulse", 32'(abort_pulse), 32'd1);
        checkOutput("t5_grant_cleared", 32'(grant), 32'd0);
        checkOutput("t5_busy_cleared", 32'(busy), 32'd0);
        checkOutput("t5_line_idle", 32'(uart_tx), 32'd1);
        @(negedge clk);
        checkOutput("t5_abort_one_cycle", 32'(abort_pulse), 32'd0);
        checkOutput("t5_b_granted", 32'(grant), 32'd2);
        applyStimulus(1'b1, 8'h66, 1'b1);
        b_valid = 1'b0;
        waitIdle();
        checkOutput("t5_byte_count", 32'(rxQ.size() - base), 32'd4);
        checkOutput("t5_hdr_a", 32'(rxQ[base]), 32'h10);
        checkOutput("t5_data_a", 32'(rxQ[base + 1]), 32'h55);
        checkOutput("t5_hdr_b", 32'(rxQ[base + 2]), 32'h20);
        checkOutput("t5_data_b", 32'(rxQ[base + 3]), 32'h66);

        $display("[TB] reset in the middle of a payload frame");
        applyStimulus(1'b0, 8'hC3, 1'b1);
        a_valid = 1'b0;
        repeat (56) @(negedge clk);
        checkOutput("t6_bit4_on_line", 32'(uart_tx), 32'd0);
        checkOutput("t6_busy_before_reset", 32'(busy), 32'd1);
        rxMute = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_line_high", 32'(uart_tx), 32'd1);
        checkOutput("t6_no_abort", 32'(abort_pulse), 32'd0);
        checkOutput("t6_grant_off", 32'(grant), 32'd0);
        checkOutput("t6_busy_off", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (abort_pulse !== 1'b0 || uart_tx !== 1'b1) seen++;
        end
        checkOutput("t6_quiet_after_reset", 32'(seen), 32'd0);
        rxMute = 1'b0;
        base = rxQ.size(); gbase = gQ.size();
        applyStimulus(1'b1, 8'h77, 1'b1);
        b_valid = 1'b0;
        waitIdle();
        checkOutput("t6_byte_count", 32'(rxQ.size() - base), 32'd2);
        checkOutput("t6_hdr_b", 32'(rxQ[base]), 32'h20);
        checkOutput("t6_data_b", 32'(rxQ[base + 1]), 32'h77);
        checkOutput("t6_grant_log_len", 32'(gQ.size() - gbase), 32'd2);
        checkOutput("t6_grant_b", 32'(gQ[gbase]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Packet-level scheduler that shares one physical UART TX line (toward the PC) between two byte-stream requesters: A = CROC softcore, B = STM32 bridge. It grants the line to one source per packet and prepends a source header byte. It then serializes header and payload as 8N1 frames. Strict priority goes to B, with a starvation guard for A and a mid-packet stall timeout.

Parameters:
CLK_FREQ, 20000000, system clock in Hz
BAUD_RATE, 125000, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide, must be >= 2)
HDR_A, 8'h10, header byte sent before every A packet
HDR_B, 8'h20, header byte sent before every B packet
MAX_B_STREAK, 4, consecutive B grants allowed while A is waiting
STALL_CYCLES, CLKS_PER_BIT*24, max wait for next payload byte before abort

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
a_valid  in  1  A has a byte
a_data  in  8  A byte
a_last  in  1  byte is last of A packet
a_ready  out  1  A byte accepted when a_valid & a_ready
b_valid / b_data / b_last / b_ready  same as A, for source B
uart_tx  out  1  serial line, idle high
grant  out  2  one-hot owner: bit0 = A, bit1 = B; 0 when idle
busy  out  1  high in any state other than S_IDLE
abort_pulse  out  1  one-cycle pulse on stall abort

Behaviour:
- Reset (sampled on posedge clk while rst_n = 0):
  - uart_tx = 1; a_ready = b_ready = 0; grant = 0; busy = 0; abort_pulse = 0.
  - State = S_IDLE; b_streak = 0; all counters = 0.
  - Reset mid-frame: line goes high on the next edge and the packet is dropped. abort_pulse is not asserted.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
- S_IDLE: arbitration happens on any cycle where a_valid or b_valid is high.
  - B wins if b_valid, unless a_valid and b_streak == MAX_B_STREAK; in that case A wins.
  - A wins if only a_valid is high.
  - b_streak: +1 on a B grant with a_valid high; cleared on an A grant or on a B grant with a_valid low. It saturates at MAX_B_STREAK.
  - On the grant edge: grant is set, the header byte is loaded into the shifter, and the state moves to S_SHIFT. uart_tx drives the start bit from the next cycle.
  - No payload byte is consumed during the header.
- S_SHIFT: a bit counter and a baud counter drive the frame.
  - After the last stop-bit cycle: if the frame was the header, or a payload byte without last, go to S_WAIT.
  - If the frame was a payload byte with last, go to S_IDLE and clear grant on that edge.
- S_WAIT:
  - The granted source's ready is 1 (combinational from state and grant); the other source's ready is 0.
  - On valid & ready: latch data and last, load the shifter, go to S_SHIFT. The start bit appears on the next cycle, so the inter-frame gap is at most 1 cycle when data is already valid.
  - The stall counter clears on entry to S_WAIT. If it reaches STALL_CYCLES with no handshake: abort_pulse = 1 for one cycle, grant is cleared, state goes to S_IDLE, and uart_tx stays high.
- ready is never high outside S_WAIT. The non-granted source is never acknowledged.
- A valid on the non-granted source during a packet is held off; it is arbitrated only after return to S_IDLE.
- After a packet ends, S_IDLE lasts at least 1 cycle before the next grant.

Optional Feature:
UART_TX_SCHED_PARITY_EN
- Defined: an even-parity bit is inserted between data bit 7 and the stop bit, for header and payload frames alike. The frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: plain 8N1 as above. No parity logic is present.

Test Plan:
All scenarios use CLK_FREQ=1000000 and BAUD_RATE=100000 (10 cycles/bit).
1. Reset: hold rst_n=0 for 5 cycles with a_valid=1 -> uart_tx=1, grant=0, a_ready=0 throughout; start bit appears 2 cycles after rst_n rises.
2. Single A packet {8'h41, 8'h42 (last)} -> line carries 8'h10, 8'h41, 8'h42; frames are 100 cycles each; a_ready has exactly 2 handshakes; grant=2'b01 until 1 cycle after the final stop bit.
3. a_valid and b_valid rise on the same cycle with 1-byte packets -> B packet (8'h20, data) goes first, then the A packet; grant goes 2'b10 -> 0 -> 2'b01.
4. A continuously valid, B sends 6 back-to-back 1-byte packets -> grant order is B,B,B,B,A,B,B; b_streak resets after the A grant.
5. A sends 8'h55 without last, then a_valid=0 -> abort_pulse after exactly STALL_CYCLES=240 cycles in S_WAIT; grant returns to 0; a pending b_valid is granted on the next cycle.
6. Reset asserted mid-payload-frame (bit 4) -> uart_tx=1 on the next edge, no abort_pulse; the next packet starts cleanly with its header.
